// File: rtl/stack_interface_ds_router_if.sv
// Downstream stack-bus bundle: bus input side, controller port and per-lane stOp ports.
// master = the environment driving the bus and consuming outputs; slave = the router.
interface stack_interface_ds_router_if #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_LANES  = 4
);
  logic                            sb_ds_valid;
  logic [1:0]                      sb_ds_cntl;
  logic [DATA_WIDTH-1:0]           sb_ds_data;
  logic                            sb_ds_ready;
  logic                            cntl_valid;
  logic [1:0]                      cntl_cntl;
  logic [DATA_WIDTH-1:0]           cntl_data;
  logic                            cntl_ready;
  logic [NUM_LANES-1:0]            stop_valid;
  logic [NUM_LANES-1:0]            stop_eom;
  logic [NUM_LANES*DATA_WIDTH-1:0] stop_data;
  logic [NUM_LANES-1:0]            stop_ready;
  logic                            err_pulse;

  modport master (
    output sb_ds_valid, sb_ds_cntl, sb_ds_data, cntl_ready, stop_ready,
    input  sb_ds_ready, cntl_valid, cntl_cntl, cntl_data, stop_valid, stop_eom, stop_data,
           err_pulse
  );

  modport slave (
    input  sb_ds_valid, sb_ds_cntl, sb_ds_data, cntl_ready, stop_ready,
    output sb_ds_ready, cntl_valid, cntl_cntl, cntl_data, stop_valid, stop_eom, stop_data,
           err_pulse
  );
endinterface

// File: rtl/stack_interface_ds_router.sv
// Downstream stack-bus router: control packets to the controller FIFO, data packets to stOp lanes.
// Optional error counter (err_count / err_count_clr) enabled by STACK_INTF_DS_ERR_CNT_EN.

module stack_interface_ds_router_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset_poweron,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             vld_p1,
  output logic [WIDTH-1:0] dout_p1,
  input  logic             pop_ready
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] rd_ptr_n;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] count_keep;
  logic [CNT_W-1:0] count_n;
  logic             push_ok;
  logic             pop;

  assign full       = (count == CNT_W'(DEPTH));
  assign push_ok    = push && !full;
  assign pop        = vld_p1 && pop_ready;
  assign rd_ptr_n   = rd_ptr + PTR_W'(pop);
  assign count_keep = count - CNT_W'(pop);
  assign count_n    = count_keep + CNT_W'(push_ok);

  // Head register: when nothing else remains after the pop, the incoming word becomes the head.
  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      vld_p1  <= 1'b0;
      dout_p1 <= '0;
    end else begin
      wr_ptr <= wr_ptr + PTR_W'(push_ok);
      rd_ptr <= rd_ptr_n;
      count  <= count_n;
      vld_p1 <= (count_n != '0);
      if (count_keep == '0) begin
        if (push_ok) dout_p1 <= din;
      end else begin
        dout_p1 <= mem[rd_ptr_n];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end
endmodule

module stack_interface_ds_router #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_LANES  = 4,
  parameter int LANE_ID_W  = 4,
  parameter int FIFO_DEPTH = 8
) (
  input  logic clk,
  input  logic reset_poweron,
`ifdef STACK_INTF_DS_ERR_CNT_EN
  input  logic       err_count_clr,
  output logic [7:0] err_count,
`endif
  stack_interface_ds_router_if.slave bus
);
  typedef enum logic [1:0] {IDLE, FWD_CNTL, FWD_DATA, DROP} state_t;

  localparam logic [1:0]           C_SOM     = 2'b00;
  localparam logic [1:0]           C_EOM     = 2'b10;
  localparam logic [1:0]           C_SOM_EOM = 2'b11;
  localparam logic [LANE_ID_W:0]   LANES_W   = (LANE_ID_W+1)'(NUM_LANES);

  function automatic logic is_som(input logic [1:0] c);
    return (c == C_SOM) || (c == C_SOM_EOM);
  endfunction

  function automatic logic is_eom(input logic [1:0] c);
    return c[1];
  endfunction

  state_t                state, state_n;
  logic [LANE_ID_W-1:0]  cur_lane, cur_lane_n;
  logic                  armed;
  logic                  ready_raw;
  logic                  accept;
  logic                  som, eom;
  logic                  hdr_is_data;
  logic [LANE_ID_W-1:0]  hdr_lane;
  logic                  lane_ok;
  logic                  cntl_push;
  logic                  data_push;
  logic                  err_n;
  logic                  err_q;
  logic                  cntl_full;
  logic                  sel_full;
  logic [NUM_LANES-1:0]  lane_full;
  logic [NUM_LANES-1:0]  lane_vld;
  logic [NUM_LANES-1:0]  lane_eom;
  logic [NUM_LANES*DATA_WIDTH-1:0] lane_data;
  logic [DATA_WIDTH+1:0] cntl_head;

  assign som         = is_som(bus.sb_ds_cntl);
  assign eom         = is_eom(bus.sb_ds_cntl);
  assign hdr_is_data = bus.sb_ds_data[DATA_WIDTH-1];
  assign hdr_lane    = bus.sb_ds_data[DATA_WIDTH-2 -: LANE_ID_W];
  assign lane_ok     = ({1'b0, hdr_lane} < LANES_W);

  always_comb begin
    sel_full = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (cur_lane == LANE_ID_W'(i)) sel_full = lane_full[i];
    end
  end

  // IDLE gates on the controller FIFO even for data headers, which are never stored.
  always_comb begin
    ready_raw = 1'b1;
    case (state)
      IDLE, FWD_CNTL: ready_raw = !cntl_full;
      FWD_DATA:       ready_raw = !sel_full;
      default:        ready_raw = 1'b1;
    endcase
  end

  assign bus.sb_ds_ready = armed && ready_raw;
  assign accept          = bus.sb_ds_valid && bus.sb_ds_ready;

  always_comb begin
    state_n    = state;
    cur_lane_n = cur_lane;
    cntl_push  = 1'b0;
    data_push  = 1'b0;
    err_n      = 1'b0;
    if (accept) begin
      case (state)
        IDLE: begin
          if (!som) begin
            err_n = 1'b1;
          end else if (!hdr_is_data) begin
            cntl_push = 1'b1;
            if (!eom) state_n = FWD_CNTL;
          end else if (eom) begin
            err_n = 1'b1;
          end else if (lane_ok) begin
            cur_lane_n = hdr_lane;
            state_n    = FWD_DATA;
          end else begin
            err_n   = 1'b1;
            state_n = DROP;
          end
        end
        FWD_CNTL: begin
          if (som) begin
            err_n   = 1'b1;
            state_n = DROP;
          end else begin
            cntl_push = 1'b1;
            if (eom) state_n = IDLE;
          end
        end
        FWD_DATA: begin
          if (som) begin
            err_n   = 1'b1;
            state_n = DROP;
          end else begin
            data_push = 1'b1;
            if (eom) state_n = IDLE;
          end
        end
        DROP: begin
          if (bus.sb_ds_cntl == C_EOM) state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // armed holds off acceptance for the first cycle after reset release.
  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      state    <= IDLE;
      cur_lane <= '0;
      armed    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_n;
      cur_lane <= cur_lane_n;
      armed    <= 1'b1;
      err_q    <= err_n;
    end
  end

  assign bus.err_pulse = err_q;

  stack_interface_ds_router_fifo #(
    .WIDTH (DATA_WIDTH + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_cntl_fifo (
    .clk           (clk),
    .reset_poweron (reset_poweron),
    .push          (cntl_push),
    .din           ({bus.sb_ds_cntl, bus.sb_ds_data}),
    .full          (cntl_full),
    .vld_p1        (bus.cntl_valid),
    .dout_p1       (cntl_head),
    .pop_ready     (bus.cntl_ready)
  );

  assign bus.cntl_cntl = cntl_head[DATA_WIDTH+1:DATA_WIDTH];
  assign bus.cntl_data = cntl_head[DATA_WIDTH-1:0];

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    logic [DATA_WIDTH:0] head;

    stack_interface_ds_router_fifo #(
      .WIDTH (DATA_WIDTH + 1),
      .DEPTH (FIFO_DEPTH)
    ) u_lane_fifo (
      .clk           (clk),
      .reset_poweron (reset_poweron),
      .push          (data_push && (cur_lane == LANE_ID_W'(g))),
      .din           ({eom, bus.sb_ds_data}),
      .full          (lane_full[g]),
      .vld_p1        (lane_vld[g]),
      .dout_p1       (head),
      .pop_ready     (bus.stop_ready[g])
    );

    assign lane_eom[g]                             = head[DATA_WIDTH];
    assign lane_data[g*DATA_WIDTH +: DATA_WIDTH]   = head[DATA_WIDTH-1:0];
  end

  assign bus.stop_valid = lane_vld;
  assign bus.stop_eom   = lane_eom;
  assign bus.stop_data  = lane_data;

`ifdef STACK_INTF_DS_ERR_CNT_EN
  always_ff @(posedge clk or negedge reset_poweron) begin
    if (!reset_poweron) begin
      err_count <= '0;
    end else if (err_count_clr) begin
      err_count <= '0;
    end else if (err_q && (err_count != 8'hFF)) begin
      err_count <= err_count + 8'd1;
    end
  end
`endif
endmodule

// File: tb/tb_stack_interface_ds_router.sv
// Bench for stack_interface_ds_router: vector table plus scoreboard queues for cntl and lane outputs.
module tb_stack_interface_ds_router;
  localparam int DW    = 64;
  localparam int NL    = 4;
  localparam int LID   = 4;
  localparam int DEPTH = 8;
  localparam int DNONE = -1;
  localparam int DCNTL = -2;

  localparam logic [1:0] SOM = 2'b00, MOM = 2'b01, EOM = 2'b10, SOE = 2'b11;

  typedef struct {
    logic [1:0]    cntl;
    logic [DW-1:0] data;
    int            dest;
    bit            eom;
    bit            err;
  } vec_t;

  logic clk;
  logic reset_poweron;
  int   n_pass;
  int   n_total;

  vec_t          vecs[$];
  logic [DW+1:0] cntl_q[$];
  logic [DW:0]   lq[NL][$];

  stack_interface_ds_router_if #(.DATA_WIDTH(DW), .NUM_LANES(NL)) bus();

  stack_interface_ds_router #(
    .DATA_WIDTH (DW),
    .NUM_LANES  (NL),
    .LANE_ID_W  (LID),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk           (clk),
    .reset_poweron (reset_poweron),
    .bus           (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [DW-1:0] hdr(input bit is_data, input int lane);
    logic [DW-1:0] h;
    logic [31:0]   l;
    h = '0;
    l = lane;
    h[DW-1] = is_data;
    h[DW-2 -: LID] = l[LID-1:0];
    return h;
  endfunction

  task automatic add(input logic [1:0] c, input logic [DW-1:0] d, input int dest,
                     input bit eom, input bit err);
    vec_t v;
    v.cntl = c; v.data = d; v.dest = dest; v.eom = eom; v.err = err;
    vecs.push_back(v);
  endtask

  // Drives one word, waits (bounded) for acceptance, then checks err_pulse the cycle after.
  task automatic send(input vec_t v);
    int waited;
    waited = 0;
    @(posedge clk); #1;
    bus.sb_ds_valid = 1'b1;
    bus.sb_ds_cntl  = v.cntl;
    bus.sb_ds_data  = v.data;
    @(negedge clk);
    while (!bus.sb_ds_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.sb_ds_ready) begin
      n_total++;
      $display("FAIL accept_timeout: word %0h not accepted after %0d cycles", v.data, waited);
      bus.sb_ds_valid = 1'b0;
      return;
    end
    if (v.dest == DCNTL) cntl_q.push_back({v.cntl, v.data});
    else if (v.dest >= 0) lq[v.dest].push_back({v.eom, v.data});
    @(posedge clk); #1;
    bus.sb_ds_valid = 1'b0;
    @(negedge clk);
    check($sformatf("err_pulse_after_%0h", v.data), bus.err_pulse, v.err);
  endtask

  task automatic send_w(input logic [1:0] c, input logic [DW-1:0] d, input int dest,
                        input bit eom, input bit err);
    vec_t v;
    v.cntl = c; v.data = d; v.dest = dest; v.eom = eom; v.err = err;
    send(v);
  endtask

  // Output monitor: every pop is compared against the scoreboard head.
  always @(negedge clk) begin
    logic [DW+1:0] ec;
    logic [DW:0]   el;
    if (reset_poweron) begin
      if (bus.cntl_valid && bus.cntl_ready) begin
        if (cntl_q.size() == 0) begin
          n_total++;
          $display("FAIL cntl_unexpected: got %0h, expected no word", bus.cntl_data);
        end else begin
          ec = cntl_q.pop_front();
          check("cntl_word", {bus.cntl_cntl, bus.cntl_data}, ec);
        end
      end
      for (int i = 0; i < NL; i++) begin
        if (bus.stop_valid[i] && bus.stop_ready[i]) begin
          if (lq[i].size() == 0) begin
            n_total++;
            $display("FAIL lane%0d_unexpected: got %0h, expected no word", i,
                     bus.stop_data[i*DW +: DW]);
          end else begin
            el = lq[i].pop_front();
            check($sformatf("lane%0d_word", i), {bus.stop_eom[i], bus.stop_data[i*DW +: DW]}, el);
          end
        end
      end
    end
  end

  initial begin
    n_pass = 0;
    n_total = 0;
    reset_poweron   = 1'b0;
    bus.sb_ds_valid = 1'b0;
    bus.sb_ds_cntl  = 2'b00;
    bus.sb_ds_data  = '0;
    bus.cntl_ready  = 1'b1;
    bus.stop_ready  = '1;

    add(SOM, 64'hA1, DCNTL, 0, 0);
    add(MOM, 64'hA2, DCNTL, 0, 0);
    add(EOM, 64'hA3, DCNTL, 0, 0);
    add(SOM, hdr(1, 2), DNONE, 0, 0);
    add(MOM, 64'h11, 2, 0, 0);
    add(EOM, 64'h22, 2, 1, 0);
    add(SOM, hdr(1, 7), DNONE, 0, 1);
    add(MOM, 64'h71, DNONE, 0, 0);
    add(EOM, 64'h72, DNONE, 0, 0);
    add(SOE, 64'hB0, DCNTL, 0, 0);
    add(SOM, hdr(1, 1), DNONE, 0, 0);
    add(MOM, 64'h33, 1, 0, 0);
    add(SOM, 64'hB1, DNONE, 0, 1);
    add(MOM, 64'hB2, DNONE, 0, 0);
    add(EOM, 64'hB3, DNONE, 0, 0);
    add(MOM, 64'hB4, DNONE, 0, 1);
    add(EOM, 64'hB5, DNONE, 0, 1);
    add(SOE, hdr(1, 0), DNONE, 0, 1);
    add(SOM, hdr(1, 3), DNONE, 0, 0);
    add(EOM, 64'h44, 3, 1, 0);
    add(SOM, 64'hC0, DCNTL, 0, 0);
    add(SOE, 64'hC5, DNONE, 0, 1);
    add(EOM, 64'hC6, DNONE, 0, 0);
    add(SOE, 64'hC1, DCNTL, 0, 0);

    repeat (2) @(negedge clk);
    check("rst_ready", bus.sb_ds_ready, 0);
    check("rst_cntl_valid", bus.cntl_valid, 0);
    check("rst_stop_valid", bus.stop_valid, 0);
    check("rst_err", bus.err_pulse, 0);
    check("rst_cntl_data", bus.cntl_data, 0);
    check("rst_stop_data0", bus.stop_data[DW-1:0], 0);
    @(posedge clk); #1;
    reset_poweron = 1'b1;
    @(negedge clk);
    check("ready_first_cycle", bus.sb_ds_ready, 0);

    for (int i = 0; i < vecs.size(); i++) send(vecs[i]);
    repeat (4) @(negedge clk);

    // Latency and hold with a stalled controller.
    @(posedge clk); #1;
    bus.cntl_ready = 1'b0;
    send_w(SOE, 64'hD0, DCNTL, 0, 0);
    check("lat_cntl_valid", bus.cntl_valid, 1);
    check("lat_cntl_data", bus.cntl_data, 64'hD0);
    check("lat_cntl_cntl", bus.cntl_cntl, SOE);
    repeat (2) @(negedge clk);
    check("hold_cntl_data", bus.cntl_data, 64'hD0);
    @(posedge clk); #1;
    bus.cntl_ready = 1'b1;
    repeat (3) @(negedge clk);

    // Lane 2 stalled with a 10-word payload.
    @(posedge clk); #1;
    bus.stop_ready[2] = 1'b0;
    send_w(SOM, hdr(1, 2), DNONE, 0, 0);
    for (int k = 1; k <= 8; k++) send_w(MOM, 64'h100 + k, 2, 0, 0);
    check("stall_ready_full", bus.sb_ds_ready, 0);
    check("stall_head_hold", bus.stop_data[2*DW +: DW], 64'h101);
    fork
      send_w(MOM, 64'h109, 2, 0, 0);
      begin
        repeat (3) begin
          @(negedge clk);
          check("stall_ready_held", bus.sb_ds_ready, 0);
        end
        @(posedge clk); #1;
        bus.stop_ready[2] = 1'b1;
      end
    join
    send_w(EOM, 64'h10A, 2, 1, 0);
    repeat (12) @(negedge clk);
    check("stall_drained", lq[2].size(), 0);

    // A full, stalled lane does not block a packet to another lane.
    @(posedge clk); #1;
    bus.stop_ready[2] = 1'b0;
    send_w(SOM, hdr(1, 2), DNONE, 0, 0);
    for (int k = 1; k <= 7; k++) send_w(MOM, 64'h200 + k, 2, 0, 0);
    send_w(EOM, 64'h208, 2, 1, 0);
    check("idle_ready_lane2_full", bus.sb_ds_ready, 1);
    send_w(SOM, hdr(1, 0), DNONE, 0, 0);
    send_w(MOM, 64'h55, 0, 0, 0);
    send_w(EOM, 64'h66, 0, 1, 0);
    repeat (4) @(negedge clk);
    check("lane0_drained", bus.stop_valid[0], 0);
    check("lane2_still_held", bus.stop_valid[2], 1);
    @(posedge clk); #1;
    bus.stop_ready[2] = 1'b1;
    repeat (12) @(negedge clk);

    // Reset mid-packet with three words parked in the controller FIFO.
    @(posedge clk); #1;
    bus.cntl_ready = 1'b0;
    send_w(SOM, 64'hE1, DCNTL, 0, 0);
    send_w(MOM, 64'hE2, DCNTL, 0, 0);
    send_w(MOM, 64'hE3, DCNTL, 0, 0);
    check("pre_rst_cntl_valid", bus.cntl_valid, 1);
    @(posedge clk); #1;
    reset_poweron = 1'b0;
    #1;
    check("midrst_cntl_valid", bus.cntl_valid, 0);
    check("midrst_ready", bus.sb_ds_ready, 0);
    check("midrst_stop_valid", bus.stop_valid, 0);
    cntl_q.delete();
    for (int i = 0; i < NL; i++) lq[i].delete();
    @(posedge clk); #1;
    reset_poweron = 1'b1;
    bus.cntl_ready = 1'b1;
    @(negedge clk);
    check("ready_first_cycle_2", bus.sb_ds_ready, 0);
    send_w(MOM, 64'hF0, DNONE, 0, 1);
    send_w(SOE, 64'hF1, DCNTL, 0, 0);

    repeat (10) @(negedge clk);
    check("end_cntl_q_empty", cntl_q.size(), 0);
    for (int i = 0; i < NL; i++) check($sformatf("end_lane%0d_q_empty", i), lq[i].size(), 0);
    check("end_cntl_valid", bus.cntl_valid, 0);
    check("end_stop_valid", bus.stop_valid, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
